lcd1602_rx: RTL and testbench
=============================

LCD1602_RX -- requirements
Module: lcd1602_rx

Interface
REQ-001 Parameter: BUSY_CYCLES, 40, clk cycles busy is held after each accepted transfer.
REQ-002 Parameter: SYNC_STAGES, 2, synchroniser depth on all bus inputs.
REQ-003 Clock is clk; reset is rst_n, synchronous, active-low; single clock domain.
REQ-004 clk  in  1  system clock.
REQ-005 rst_n  in  1  synchronous active-low reset.
REQ-006 lcd_rs  in  1  register select from the LCD bus: 0 = command, 1 = data.
REQ-007 lcd_rw  in  1  bus read/write: 0 = write; 1 = read, ignored by this block.
REQ-008 lcd_en  in  1  bus enable; a transfer completes on its falling edge.
REQ-009 lcd_dat  in  8  bus data.
REQ-010 rd_addr  in  5  display buffer read index: 0-15 = line 1, 16-31 = line 2.
REQ-011 rd_char  out  8  buffer byte at rd_addr, registered.
REQ-012 cmd_valid  out  1  one-cycle pulse when a command byte is accepted.
REQ-013 cmd_code  out  8  last accepted command byte.
REQ-014 char_valid  out  1  one-cycle pulse when a data byte is written to the buffer.
REQ-015 busy  out  1  emulated HD44780 busy flag.
REQ-016 overrun  out  1  one-cycle pulse when a transfer is dropped.
REQ-017 display_on  out  1  display-control D bit.
REQ-018 ddram_addr  out  5  current buffer write index.

Function
REQ-019 Synchronise lcd_rs, lcd_rw, lcd_en and lcd_dat through SYNC_STAGES flops; while synchronised en=1, latch rs, rw and dat every cycle.
REQ-020 Detect a transfer on a synchronised en transition 1->0; use the latched rs, rw and dat; rw=1 transfers produce no output and no state change.
REQ-021 FSM states: FILL (write 0x20 to one entry per cycle, indices 0..31), BUSY (count down BUSY_CYCLES), IDLE.
REQ-022 A transfer detected in IDLE is accepted; a transfer detected in FILL or BUSY is dropped and pulses overrun, with no other effect.
REQ-023 After an accepted transfer: 0x01 -> FILL, then BUSY; any other byte -> BUSY; BUSY expiry -> IDLE; busy = 1 in FILL and BUSY.
REQ-024 Command 0x01: fill the buffer with 0x20, set ddram_addr=0, set increment mode.
REQ-025 Commands 0x02/0x03: set ddram_addr=0; buffer unchanged.
REQ-026 Commands 0x04-0x07: set increment mode from bit1 (1 = increment).
REQ-027 Commands 0x08-0x0F: display_on = bit2; cursor and blink bits ignored.
REQ-028 Commands 0x10-0x1F: if bit3=0, move ddram_addr by +1 when bit2=1 and by -1 when bit2=0, modulo 32; if bit3=1 (display shift), no change.
REQ-029 Commands 0x20-0x7F (function set, CGRAM address): cmd_valid pulse only.
REQ-030 Commands 0x80-0xFF: ddram_addr = {bit6, bits3:0}; bits5:4 ignored.
REQ-031 Data (rs=1): buf[ddram_addr] = dat; then ddram_addr moves by +1 or -1, modulo 32, per the mode; char_valid pulses.
REQ-032 Event latency: cmd_valid, char_valid and overrun pulse 1 cycle after the synchronised falling edge; the buffer write is visible on rd_char 2 cycles after that edge.
REQ-033 rd_char is registered with 1-cycle latency from rd_addr, and is readable in every state, including FILL.

Reset
REQ-034 Reset gives: FSM=FILL, ddram_addr=0, increment mode, display_on=0, cmd_code=0x00, rd_char=0x00, all pulses 0, busy=1, synchronisers cleared.
REQ-035 Reset asserted mid-FILL or mid-BUSY restarts FILL at index 0; after reset release busy is high for 32+BUSY_CYCLES cycles.

Structure
REQ-036 Shared package lcd1602_pkg holds: command range constants, the space character 0x20, buffer depth 32 and the FSM state enum.
REQ-037 One sub-module, lcd_bus_sync, holds the synchroniser, the latch and the falling-edge detector and outputs xfer_stb, xfer_rs, xfer_rw and xfer_dat.

Verification
REQ-038 After reset and busy low, send 0x30, 0x0C, 0x06, 0x01, then "HELLO WORLD!", each sent after busy drops -> indices 0-11 read "HELLO WORLD!", indices 12-31 read 0x20, display_on=1, ddram_addr=12.
REQ-039 Send 0xC0 then 'A' -> buf[16]=0x41, ddram_addr=17.
REQ-040 Send 0x04, then 0x80, then 'Z' -> buf[0]=0x5A, ddram_addr=31 (wrap).
REQ-041 Send a data byte while busy=1 -> overrun pulses once, buffer and ddram_addr unchanged.
REQ-042 Send an rw=1 transfer -> no cmd_valid, char_valid or overrun, and busy stays 0.
REQ-043 Assert rst_n=0 for 1 cycle during FILL at index 10 -> FILL restarts at index 0, all 32 entries read 0x20, busy high for 32+BUSY_CYCLES cycles.

Source files
------------

// File: rtl/lcd1602_pkg.sv
// lcd1602_pkg: shared definitions for the HD44780-style LCD bus receiver.
//   - command range boundaries used to decode instruction bytes
//   - space character written by the clear/fill sequence
//   - display buffer depth (two 16-character lines)
//   - receiver FSM state enum and a command classifier
package lcd1602_pkg;

    localparam int          BUF_DEPTH    = 32;
    localparam int          ADDR_W       = $clog2(BUF_DEPTH);
    localparam logic [7:0]  CHAR_SPACE   = 8'h20;

    // Lower bound of each instruction range; the highest set bit selects the range.
    localparam logic [7:0]  CMD_CLEAR    = 8'h01;
    localparam logic [7:0]  CMD_HOME_LO  = 8'h02;
    localparam logic [7:0]  CMD_ENTRY_LO = 8'h04;
    localparam logic [7:0]  CMD_DISP_LO  = 8'h08;
    localparam logic [7:0]  CMD_SHIFT_LO = 8'h10;
    localparam logic [7:0]  CMD_FUNC_LO  = 8'h20;
    localparam logic [7:0]  CMD_DDRAM_LO = 8'h80;

    typedef enum logic [1:0] {
        ST_FILL,
        ST_BUSY,
        ST_IDLE
    } lcd_state_e;

    typedef enum logic [2:0] {
        CK_CLEAR,
        CK_HOME,
        CK_ENTRY,
        CK_DISP,
        CK_SHIFT,
        CK_NONE,
        CK_DDRAM
    } cmd_kind_e;

    // Function set, CGRAM address and 0x00 fall into CK_NONE: they only pulse cmd_valid.
    function automatic cmd_kind_e cmd_kind(input logic [7:0] c);
        cmd_kind_e k;
        if (c >= CMD_DDRAM_LO)      k = CK_DDRAM;
        else if (c >= CMD_FUNC_LO)  k = CK_NONE;
        else if (c >= CMD_SHIFT_LO) k = CK_SHIFT;
        else if (c >= CMD_DISP_LO)  k = CK_DISP;
        else if (c >= CMD_ENTRY_LO) k = CK_ENTRY;
        else if (c >= CMD_HOME_LO)  k = CK_HOME;
        else if (c == CMD_CLEAR)    k = CK_CLEAR;
        else                        k = CK_NONE;
        return k;
    endfunction

endpackage

// File: rtl/lcd1602_rx_if.sv
// lcd1602_rx_if: parallel LCD bus as seen by the receiver.
//   lcd_rs  : 0 = command, 1 = data
//   lcd_rw  : 0 = write, 1 = read
//   lcd_en  : strobe, transfer completes on its falling edge
//   lcd_dat : 8-bit bus data
// master drives the bus (host/testbench), slave observes it (receiver).
interface lcd1602_rx_if;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_en;
    logic [7:0] lcd_dat;

    modport master (output lcd_rs, lcd_rw, lcd_en, lcd_dat);
    modport slave  (input  lcd_rs, lcd_rw, lcd_en, lcd_dat);
endinterface

// File: rtl/lcd_bus_sync.sv
// lcd_bus_sync: brings the asynchronous LCD bus into the clk domain.
//   clk, rst_n     : system clock, synchronous active-low reset
//   bus            : LCD bus (slave modport)
//   xfer_stb       : one-cycle strobe on synchronised lcd_en 1->0
//   xfer_rs/rw/dat : bus fields latched while synchronised lcd_en was high
// All bus bits share one synchroniser chain so rs/rw/dat stay aligned with en.
module lcd_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    lcd1602_rx_if.slave bus,
    output logic       xfer_stb,
    output logic       xfer_rs,
    output logic       xfer_rw,
    output logic [7:0] xfer_dat
);

    // Packing: [10]=rw, [9]=rs, [8]=en, [7:0]=dat
    logic [SYNC_STAGES-1:0][10:0] sync_q;
    logic [10:0]                  s;
    logic                         en_s;
    logic                         en_q;

    assign s        = sync_q[SYNC_STAGES-1];
    assign en_s     = s[8];
    assign xfer_stb = en_q & ~en_s;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q   <= '0;
            en_q     <= 1'b0;
            xfer_rs  <= 1'b0;
            xfer_rw  <= 1'b0;
            xfer_dat <= 8'h00;
        end else begin
            sync_q[0] <= {bus.lcd_rw, bus.lcd_rs, bus.lcd_en, bus.lcd_dat};
            for (int i = 1; i < SYNC_STAGES; i++)
                sync_q[i] <= sync_q[i-1];
            en_q <= en_s;
            // Hold the last value seen with en high; the strobe cycle sees en low.
            if (en_s) begin
                xfer_rw  <= s[10];
                xfer_rs  <= s[9];
                xfer_dat <= s[7:0];
            end
        end
    end

endmodule

// File: rtl/lcd1602_rx.sv
// lcd1602_rx: HD44780-style receiver with a 2x16 display buffer.
//   clk, rst_n  : system clock, synchronous active-low reset
//   bus         : LCD bus (rs, rw, en, dat), slave modport
//   rd_addr     : buffer read index (0-15 line 1, 16-31 line 2)
//   rd_char     : registered buffer byte at rd_addr
//   cmd_valid   : pulse on accepted command, cmd_code holds it
//   char_valid  : pulse on accepted data byte
//   busy        : emulated busy flag (FILL or BUSY)
//   overrun     : pulse when a write transfer arrives while busy
//   display_on  : display-control D bit
//   ddram_addr  : current buffer write index
module lcd1602_rx
    import lcd1602_pkg::*;
#(
    parameter int BUSY_CYCLES = 40,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    lcd1602_rx_if.slave       bus,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_char,
    output logic              cmd_valid,
    output logic [7:0]        cmd_code,
    output logic              char_valid,
    output logic              busy,
    output logic              overrun,
    output logic              display_on,
    output logic [ADDR_W-1:0] ddram_addr
);

    localparam int CNT_W = $clog2(BUSY_CYCLES + 1);

    lcd_state_e        state, state_nx;
    logic [ADDR_W-1:0] fill_idx;
    logic [CNT_W-1:0]  busy_cnt;
    logic              inc_mode;
    logic [7:0]        mem [BUF_DEPTH];

    logic              xfer_stb, xfer_rs, xfer_rw;
    logic [7:0]        xfer_dat;
    logic              accept, is_clear, wr_en;
    logic [ADDR_W-1:0] wr_addr, addr_step;
    logic [7:0]        wr_data;

    lcd_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .xfer_stb (xfer_stb),
        .xfer_rs  (xfer_rs),
        .xfer_rw  (xfer_rw),
        .xfer_dat (xfer_dat)
    );

    // Reads (rw=1) are invisible here: no accept, no overrun.
    assign accept    = xfer_stb & ~xfer_rw & (state == ST_IDLE);
    assign is_clear  = ~xfer_rs & (xfer_dat == CMD_CLEAR);
    // Adding all-ones is -1 modulo the buffer depth.
    assign addr_step = inc_mode ? ADDR_W'(1) : '1;
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_FILL;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_FILL: if (fill_idx == ADDR_W'(BUF_DEPTH - 1)) state_nx = ST_BUSY;
            ST_BUSY: if (busy_cnt == '0) state_nx = ST_IDLE;
            ST_IDLE: if (accept) state_nx = is_clear ? ST_FILL : ST_BUSY;
            default: state_nx = ST_FILL;
        endcase
    end

    // Single write port: fill owns it in FILL, accepted data in IDLE.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = fill_idx;
        wr_data = CHAR_SPACE;
        if (state == ST_FILL) begin
            wr_en = 1'b1;
        end else if (accept && xfer_rs) begin
            wr_en   = 1'b1;
            wr_addr = ddram_addr;
            wr_data = xfer_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) rd_char <= 8'h00;
        else        rd_char <= mem[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fill_idx   <= '0;
            busy_cnt   <= '0;
            inc_mode   <= 1'b1;
            display_on <= 1'b0;
            cmd_code   <= 8'h00;
            ddram_addr <= '0;
            cmd_valid  <= 1'b0;
            char_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            cmd_valid  <= 1'b0;
            char_valid <= 1'b0;
            overrun    <= 1'b0;

            if (state == ST_FILL)            fill_idx <= fill_idx + 1'b1;
            else if (accept && is_clear)     fill_idx <= '0;

            // Load on entry so BUSY lasts exactly BUSY_CYCLES cycles.
            if (state_nx == ST_BUSY && state != ST_BUSY)
                busy_cnt <= CNT_W'(BUSY_CYCLES - 1);
            else if (state == ST_BUSY)
                busy_cnt <= busy_cnt - 1'b1;

            if (xfer_stb && !xfer_rw && state != ST_IDLE) begin
                overrun <= 1'b1;
            end else if (accept && xfer_rs) begin
                char_valid <= 1'b1;
                ddram_addr <= ddram_addr + addr_step;
            end else if (accept) begin
                cmd_valid <= 1'b1;
                cmd_code  <= xfer_dat;
                case (cmd_kind(xfer_dat))
                    CK_CLEAR: begin
                        ddram_addr <= '0;
                        inc_mode   <= 1'b1;
                    end
                    CK_HOME:  ddram_addr <= '0;
                    CK_ENTRY: inc_mode   <= xfer_dat[1];
                    CK_DISP:  display_on <= xfer_dat[2];
                    CK_SHIFT: if (!xfer_dat[3])
                                  ddram_addr <= ddram_addr + (xfer_dat[2] ? ADDR_W'(1) : '1);
                    CK_DDRAM: ddram_addr <= {xfer_dat[6], xfer_dat[3:0]};
                    default:  ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lcd1602_rx.sv
// tb_lcd1602_rx: directed scenarios plus randomized transfers for lcd1602_rx,
// checked against a byte-level model of the display controller.
module tb_lcd1602_rx;

    localparam int BC = 20;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] rd_addr;
    logic [7:0] rd_char;
    logic       cmd_valid;
    logic [7:0] cmd_code;
    logic       char_valid;
    logic       busy;
    logic       overrun;
    logic       display_on;
    logic [4:0] ddram_addr;

    always #5 clk = ~clk;

    lcd1602_rx_if bus ();

    lcd1602_rx #(.BUSY_CYCLES(BC), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .rd_addr    (rd_addr),
        .rd_char    (rd_char),
        .cmd_valid  (cmd_valid),
        .cmd_code   (cmd_code),
        .char_valid (char_valid),
        .busy       (busy),
        .overrun    (overrun),
        .display_on (display_on),
        .ddram_addr (ddram_addr)
    );

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Event monitor: pulse counts and busy run lengths, sampled on negedge.
    int n_cmd = 0, n_chr = 0, n_ovr = 0, busy_hi = 0, run = 0, last_run = 0;
    always @(negedge clk) begin
        if (cmd_valid)  n_cmd++;
        if (char_valid) n_chr++;
        if (overrun)    n_ovr++;
        if (busy) begin
            busy_hi++;
            run++;
        end else begin
            if (run != 0) last_run = run;
            run = 0;
        end
    end

    // Behavioural model of the controller state.
    logic [7:0] m_buf [32];
    int m_addr, m_inc, m_disp, m_cmd, m_run;

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_buf[i] = 8'h20;
        m_addr = 0; m_inc = 1; m_disp = 0; m_cmd = 0;
    endtask

    task automatic model_apply(input bit rs, input int d);
        m_run = BC;
        if (rs) begin
            m_buf[m_addr] = 8'(d);
            m_addr = (m_addr + (m_inc ? 1 : 31)) % 32;
        end else begin
            m_cmd = d;
            if (d == 1) begin
                for (int i = 0; i < 32; i++) m_buf[i] = 8'h20;
                m_addr = 0; m_inc = 1; m_run = 32 + BC;
            end else if (d >= 2 && d <= 3) m_addr = 0;
            else if (d >= 4 && d <= 7)   m_inc  = (d / 2) % 2;
            else if (d >= 8 && d <= 15)  m_disp = (d / 4) % 2;
            else if (d >= 16 && d <= 31) begin
                if ((d / 8) % 2 == 0) m_addr = (m_addr + (((d / 4) % 2) ? 1 : 31)) % 32;
            end else if (d >= 128) m_addr = ((d / 64) % 2) * 16 + d % 16;
        end
    endtask

    task automatic check_state();
        chk("ddram_addr", ddram_addr, m_addr);
        chk("display_on", display_on, m_disp);
        chk("cmd_code",   cmd_code,   m_cmd);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 2000 && busy; i++) @(negedge clk);
        chk("idle_timeout", busy, 0);
        @(negedge clk);
    endtask

    // Drive one bus cycle, then scramble the bus fields once en is low.
    task automatic pulse_en(input bit rs, input bit rw, input logic [7:0] d);
        @(negedge clk);
        bus.lcd_rs  = rs;
        bus.lcd_rw  = rw;
        bus.lcd_dat = d;
        bus.lcd_en  = 1'b1;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        bus.lcd_en  = 1'b0;
        bus.lcd_rs  = 1'($urandom);
        bus.lcd_rw  = 1'($urandom);
        bus.lcd_dat = 8'($urandom);
    endtask

    // mode 0: accepted, full check; 1: accepted, pulses only; 2: expect drop
    task automatic xfer(input bit rs, input bit rw, input logic [7:0] d, input int mode);
        int c0, h0, o0, b0;
        c0 = n_cmd; h0 = n_chr; o0 = n_ovr; b0 = busy_hi;
        pulse_en(rs, rw, d);
        repeat (6) @(negedge clk);
        if (rw) begin
            chk("rw_cmd_pulse",  n_cmd - c0, 0);
            chk("rw_char_pulse", n_chr - h0, 0);
            chk("rw_overrun",    n_ovr - o0, 0);
            chk("rw_busy",       busy_hi - b0, 0);
            check_state();
        end else if (mode == 2) begin
            chk("drop_overrun",    n_ovr - o0, 1);
            chk("drop_cmd_pulse",  n_cmd - c0, 0);
            chk("drop_char_pulse", n_chr - h0, 0);
        end else begin
            model_apply(rs, d);
            chk("cmd_pulse",  n_cmd - c0, rs ? 0 : 1);
            chk("char_pulse", n_chr - h0, rs ? 1 : 0);
            chk("no_overrun", n_ovr - o0, 0);
            if (mode == 0) begin
                wait_idle();
                chk("busy_len", last_run, m_run);
                check_state();
            end
        end
    endtask

    task automatic rd_one(input int idx, output logic [7:0] v);
        rd_addr = 5'(idx);
        @(negedge clk);
        v = rd_char;
    endtask

    task automatic rd_check_all();
        logic [7:0] v;
        for (int i = 0; i < 32; i++) begin
            rd_one(i, v);
            chk($sformatf("buf%0d", i), v, m_buf[i]);
        end
    endtask

    // Called right after rst_n rises on a negedge; counts cycles with busy high.
    task automatic reset_busy_len();
        int cnt = 0;
        while (busy && cnt < 1000) begin
            cnt++;
            @(negedge clk);
        end
        chk("rst_busy_len", cnt, 32 + BC);
    endtask

    initial begin
        string s;
        logic [7:0] v;
        int r;

        bus.lcd_rs = 1'b0; bus.lcd_rw = 1'b0; bus.lcd_en = 1'b0; bus.lcd_dat = 8'h00;
        rd_addr = 5'd0;
        rst_n   = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);

        chk("rst_rd_char",    rd_char, 0);
        chk("rst_busy",       busy, 1);
        chk("rst_ddram",      ddram_addr, 0);
        chk("rst_display_on", display_on, 0);
        chk("rst_cmd_code",   cmd_code, 0);
        chk("rst_pulses",     {cmd_valid, char_valid, overrun}, 0);

        rst_n = 1'b1;
        reset_busy_len();
        @(negedge clk);

        // Init sequence and greeting
        xfer(0, 0, 8'h30, 0);
        xfer(0, 0, 8'h0C, 0);
        xfer(0, 0, 8'h06, 0);
        xfer(0, 0, 8'h01, 0);
        s = "HELLO WORLD!";
        for (int i = 0; i < s.len(); i++) xfer(1, 0, s[i], 0);
        rd_check_all();
        chk("hello_ddram", ddram_addr, 12);
        chk("hello_disp",  display_on, 1);

        // Second line
        xfer(0, 0, 8'hC0, 0);
        xfer(1, 0, 8'h41, 0);
        chk("line2_ddram", ddram_addr, 17);
        rd_one(16, v);
        chk("line2_buf16", v, 8'h41);

        // Decrement mode wraps below zero
        xfer(0, 0, 8'h04, 0);
        xfer(0, 0, 8'h80, 0);
        xfer(1, 0, 8'h5A, 0);
        chk("wrap_ddram", ddram_addr, 31);
        rd_one(0, v);
        chk("wrap_buf0", v, 8'h5A);

        // Data while busy is dropped
        xfer(0, 0, 8'h14, 1);
        xfer(1, 0, 8'h55, 2);
        wait_idle();
        chk("drop_busy_len", last_run, m_run);
        check_state();
        rd_check_all();

        // Read cycle is ignored
        xfer(1, 1, 8'h66, 0);

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 11);
            case (r)
                0, 1, 2, 3, 4: xfer(1, 0, 8'($urandom_range(32, 126)), 0);
                5:  xfer(0, 0, 8'($urandom_range(0, 255)), 0);
                6:  xfer(0, 0, 8'($urandom_range(128, 255)), 0);
                7:  xfer(0, 0, 8'($urandom_range(16, 31)), 0);
                8:  xfer(0, 0, 8'($urandom_range(4, 15)), 0);
                9:  xfer(1'($urandom), 1, 8'($urandom), 0);
                10: begin
                    xfer(1, 0, 8'($urandom_range(32, 126)), 1);
                    xfer(1'($urandom), 0, 8'($urandom), 2);
                    wait_idle();
                    chk("rnd_drop_busy_len", last_run, m_run);
                    check_state();
                end
                default: xfer(0, 0, 8'($urandom_range(2, 3)), 0);
            endcase
        end
        rd_check_all();

        // Reset in the middle of a clear: fill restarts from index 0
        pulse_en(0, 0, 8'h01);
        for (int i = 0; i < 50 && !busy; i++) @(negedge clk);
        chk("clear_busy", busy, 1);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        reset_busy_len();
        @(negedge clk);
        check_state();
        rd_check_all();

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
